// File: rtl/vga_timing_pkg.sv
// Vertical timing presets, mode encodings and sync polarities shared by the
// VGA raster logic.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    MODE_350 = 2'd0,
    MODE_400 = 2'd1,
    MODE_480 = 2'd2
  } vga_mode_e;

  typedef struct packed {
    logic [10:0] sync;
    logic [10:0] back;
    logic [10:0] active;
    logic [10:0] total;
  } v_timing_t;

  // Polarity bit 1 means the sync pulse is driven high while active.
  localparam logic H_POL     = 1'b0;
  localparam logic V_POL_350 = 1'b1;
  localparam logic V_POL_400 = 1'b1;
  localparam logic V_POL_480 = 1'b0;

  localparam logic [10:0] V_SYNC_350   = 11'd2;
  localparam logic [10:0] V_BACK_350   = 11'd60;
  localparam logic [10:0] V_ACTIVE_350 = 11'd350;
  localparam logic [10:0] V_FRONT_350  = 11'd37;
  localparam logic [10:0] V_TOTAL_350  = V_SYNC_350 + V_BACK_350 + V_ACTIVE_350 + V_FRONT_350;

  localparam logic [10:0] V_SYNC_400   = 11'd2;
  localparam logic [10:0] V_BACK_400   = 11'd35;
  localparam logic [10:0] V_ACTIVE_400 = 11'd400;
  localparam logic [10:0] V_FRONT_400  = 11'd12;
  localparam logic [10:0] V_TOTAL_400  = V_SYNC_400 + V_BACK_400 + V_ACTIVE_400 + V_FRONT_400;

  localparam logic [10:0] V_SYNC_480   = 11'd2;
  localparam logic [10:0] V_BACK_480   = 11'd33;
  localparam logic [10:0] V_ACTIVE_480 = 11'd480;
  localparam logic [10:0] V_FRONT_480  = 11'd10;
  localparam logic [10:0] V_TOTAL_480  = V_SYNC_480 + V_BACK_480 + V_ACTIVE_480 + V_FRONT_480;

  // The unused encoding 2'b11 falls back to the 480-line table.
  function automatic v_timing_t v_timing(input logic [1:0] mode);
    v_timing_t t;
    case (mode)
      MODE_350: t = '{V_SYNC_350, V_BACK_350, V_ACTIVE_350, V_TOTAL_350};
      MODE_400: t = '{V_SYNC_400, V_BACK_400, V_ACTIVE_400, V_TOTAL_400};
      default:  t = '{V_SYNC_480, V_BACK_480, V_ACTIVE_480, V_TOTAL_480};
    endcase
    return t;
  endfunction

  function automatic logic v_pol(input logic [1:0] mode);
    logic p;
    case (mode)
      MODE_350: p = V_POL_350;
      MODE_400: p = V_POL_400;
      default:  p = V_POL_480;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..total-1 on each enable and flags the wrap step.
module vga_axis_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] total,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = ce && (count == total - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (ce) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_mode_sequencer.sv
// VGA raster timing with three vertical presets; mode requests are held
// pending and only take effect on the last pixel of a frame.
module vga_mode_sequencer
  import vga_timing_pkg::*;
#(
  parameter logic [1:0]  RESET_MODE = 2'd2,
  parameter logic [10:0] H_SYNC     = 11'd96,
  parameter logic [10:0] H_BACK     = 11'd48,
  parameter logic [10:0] H_ACTIVE   = 11'd640,
  parameter logic [10:0] H_TOTAL    = 11'd800
) (
  input  logic       slow_clock,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic [1:0] mode_sel,
  input  logic       mode_load,
  output logic       mode_ack,
  output logic       mode_err,
  output logic [1:0] cur_mode,
  output logic       hsync,
  output logic       vsync,
  output logic       display_enable,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [10:0] H_START = H_SYNC + H_BACK;
  localparam logic [10:0] H_END   = H_START + H_ACTIVE;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        pending;
  logic [1:0]  pending_mode;
  v_timing_t   vt;
  logic [10:0] v_start;
  logic [10:0] v_end;
  logic        visible;

  assign vt      = v_timing(cur_mode);
  assign v_start = vt.sync + vt.back;
  assign v_end   = v_start + vt.active;
  assign visible = (h_cnt >= H_START) && (h_cnt < H_END) &&
                   (v_cnt >= v_start) && (v_cnt < v_end);

  vga_axis_counter #(.WIDTH(11)) u_h_counter (
    .clk     (slow_clock),
    .reset_n (reset_n),
    .ce      (pix_ce),
    .total   (H_TOTAL),
    .count   (h_cnt),
    .wrap    (h_wrap)
  );

  // v_wrap is exactly the frame boundary: last pixel of the last line.
  vga_axis_counter #(.WIDTH(11)) u_v_counter (
    .clk     (slow_clock),
    .reset_n (reset_n),
    .ce      (h_wrap),
    .total   (vt.total),
    .count   (v_cnt),
    .wrap    (v_wrap)
  );

  always_ff @(posedge slow_clock) begin
    if (!reset_n) begin
      cur_mode       <= RESET_MODE;
      pending        <= 1'b0;
      pending_mode   <= RESET_MODE;
      mode_ack       <= 1'b0;
      mode_err       <= 1'b0;
      hsync          <= ~H_POL;
      vsync          <= ~v_pol(RESET_MODE);
      display_enable <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      mode_ack    <= 1'b0;
      mode_err    <= mode_load && (mode_sel == 2'b11);
      line_start  <= 1'b0;
      frame_start <= 1'b0;

      if (v_wrap && pending) begin
        cur_mode <= pending_mode;
        pending  <= 1'b0;
        mode_ack <= 1'b1;
      end
      // A load on the boundary cycle itself re-arms pending for the next frame.
      if (mode_load && (mode_sel != 2'b11)) begin
        pending      <= 1'b1;
        pending_mode <= mode_sel;
      end

      if (pix_ce) begin
        hsync          <= ((h_cnt < H_SYNC) == H_POL);
        vsync          <= ((v_cnt < vt.sync) == v_pol(cur_mode));
        display_enable <= visible;
        pixel_x        <= visible ? 10'(h_cnt - H_START) : 10'd0;
        pixel_y        <= visible ? 9'(v_cnt - v_start) : 9'd0;
        line_start     <= (h_cnt == 11'd0);
        frame_start    <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer using a shortened horizontal
// line (10 pixels) so whole frames of every vertical preset stay short.
module tb_vga_mode_sequencer;

  localparam int HS = 2, HB = 2, HA = 4, HT = 10;
  localparam int HSTART = HS + HB;
  localparam int EV_ACK = 0, EV_FS = 1;

  logic       slow_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_load = 1'b0;
  logic       mode_ack, mode_err, hsync, vsync, display_enable, line_start, frame_start;
  logic [1:0] cur_mode;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;

  always #5 slow_clock = ~slow_clock;

  vga_mode_sequencer #(
    .RESET_MODE(2'd2), .H_SYNC(11'(HS)), .H_BACK(11'(HB)),
    .H_ACTIVE(11'(HA)), .H_TOTAL(11'(HT))
  ) dut (
    .slow_clock(slow_clock), .reset_n(reset_n), .pix_ce(pix_ce),
    .mode_sel(mode_sel), .mode_load(mode_load), .mode_ack(mode_ack),
    .mode_err(mode_err), .cur_mode(cur_mode), .hsync(hsync), .vsync(vsync),
    .display_enable(display_enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] px;
    logic [8:0] py;
    logic       ls;
    logic       fs;
    logic       ack;
    logic       err;
    logic [1:0] mode;
  } obs_t;

  localparam obs_t RESET_OBS = '{hsync:1'b1, vsync:1'b1, de:1'b0, px:10'd0, py:9'd0,
                                 ls:1'b0, fs:1'b0, ack:1'b0, err:1'b0, mode:2'd2};

  typedef struct {
    bit         ld;
    logic [1:0] sel;
    bit         exp_err;
    logic [1:0] exp_mode;
    string      name;
  } vec_t;

  int vtot_tab[3]   = '{449, 449, 525};
  int vfirst_tab[3] = '{62, 37, 35};
  int vrows_tab[3]  = '{350, 400, 480};
  bit vpos_tab[3]   = '{1'b1, 1'b1, 1'b0};

  obs_t exp_q[$];
  obs_t cur;
  obs_t m_out;
  int   m_h, m_v, m_mode, m_pmode;
  bit   m_pend;
  int   tests = 0, fails = 0;
  int   clk_count = 0, ce_count = 0, ack_count = 0, fs_count = 0;
  int   last_fs_ce = -1, last_period = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b ack=%b err=%b mode=%0d",
                     o.hsync, o.vsync, o.de, o.px, o.py, o.ls, o.fs, o.ack, o.err, o.mode);
  endfunction

  // Reference behaviour for one clock, written from the timing tables above.
  function automatic void model_step(input bit rn, input bit ce, input bit ld, input logic [1:0] sel);
    bit boundary, in_win;
    if (!rn) begin
      m_h = 0; m_v = 0; m_mode = 2; m_pend = 1'b0; m_pmode = 0;
      m_out = RESET_OBS;
      return;
    end
    boundary = ce && (m_h == HT - 1) && (m_v == vtot_tab[m_mode] - 1);
    m_out.ls = 1'b0; m_out.fs = 1'b0; m_out.ack = 1'b0;
    m_out.err = ld && (sel == 2'd3);
    if (ce) begin
      in_win = (m_h >= HSTART) && (m_h < HSTART + HA) &&
               (m_v >= vfirst_tab[m_mode]) && (m_v < vfirst_tab[m_mode] + vrows_tab[m_mode]);
      m_out.hsync = !(m_h < HS);
      m_out.vsync = vpos_tab[m_mode] ? (m_v < 2) : !(m_v < 2);
      m_out.de    = in_win;
      m_out.px    = in_win ? 10'(m_h - HSTART) : 10'd0;
      m_out.py    = in_win ? 9'(m_v - vfirst_tab[m_mode]) : 9'd0;
      m_out.ls    = (m_h == 0);
      m_out.fs    = (m_h == 0) && (m_v == 0);
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == vtot_tab[m_mode] - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    if (boundary && m_pend) begin
      m_mode = m_pmode; m_pend = 1'b0; m_out.ack = 1'b1;
    end
    if (ld && sel != 2'd3) begin
      m_pend = 1'b1; m_pmode = int'(sel);
    end
    m_out.mode = 2'(m_mode);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    obs_t e;
    cur = '{hsync:hsync, vsync:vsync, de:display_enable, px:pixel_x, py:pixel_y,
            ls:line_start, fs:frame_start, ack:mode_ack, err:mode_err, mode:cur_mode};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard: no expected entry at cycle %0d", clk_count);
    end else begin
      e = exp_q.pop_front();
      if (cur !== e) begin
        fails++;
        $display("[TB] FAIL cycle %0d: got %s expected %s", clk_count, fmt(cur), fmt(e));
      end
    end
    clk_count++;
    if (cur.ack) ack_count++;
    if (cur.fs) begin
      fs_count++;
      if (last_fs_ce >= 0) last_period = ce_count - last_fs_ce;
      last_fs_ce = ce_count;
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit ce, input bit ld, input logic [1:0] sel);
    reset_n = rn; pix_ce = ce; mode_load = ld; mode_sel = sel;
    model_step(rn, ce, ld, sel);
    exp_q.push_back(m_out);
    if (rn && ce) ce_count++;
    @(posedge slow_clock);
    #1;
    checkOutput();
  endtask

  task automatic run_to(input int h, input int v, input int max_clk);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n < max_clk) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      n++;
    end
    if (n == max_clk) begin
      tests++; fails++;
      $display("[TB] FAIL run_to timeout: at h=%0d v=%0d wanted h=%0d v=%0d", m_h, m_v, h, v);
    end
  endtask

  task automatic run_until(input int kind, input int max_clk, output int steps);
    bit hit;
    hit = 1'b0;
    steps = 0;
    while (!hit && steps < max_clk) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
      steps++;
      hit = (kind == EV_ACK) ? cur.ack : cur.fs;
    end
    if (!hit) begin
      tests++; fails++;
      $display("[TB] FAIL wait_event %0d: not seen within %0d clocks", kind, max_clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   steps, first_de_ce, vs_low, last_px, last_py, a0, mark_ce;
    bit   ce_now;

    vecs[0] = '{1'b1, 2'd3, 1'b1, 2'd0, "err_alone"};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 2'd0, "err_one_clock"};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 2'd0, "valid_load_1"};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 2'd0, "err_keeps_pending"};
    vecs[4] = '{1'b0, 2'd0, 1'b0, 2'd0, "err_cleared"};

    // Reset and first frame in mode 2 with pix_ce every 4th clock
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    check("reset_state", (cur == RESET_OBS) ? 1 : 0, 1);
    ce_count = 0; fs_count = 0; last_fs_ce = -1;
    first_de_ce = -1; vs_low = 0; last_px = -1; last_py = -1;
    for (int i = 0; i < 4 * 5250 + 64 && fs_count < 2; i++) begin
      ce_now = ((i % 4) == 3);
      applyStimulus(1'b1, ce_now, 1'b0, 2'd0);
      if (ce_now) begin
        if (ce_count == 1) check("first_ce_frame_start", int'(cur.fs), 1);
        if (fs_count == 1 && !cur.vsync) vs_low++;
        if (cur.de && first_de_ce < 0) begin
          first_de_ce = ce_count;
          check("first_de_pixel_x", int'(cur.px), 0);
          check("first_de_pixel_y", int'(cur.py), 0);
        end
        if (cur.de) begin last_px = int'(cur.px); last_py = int'(cur.py); end
      end
    end
    check("t1_vsync_low_ce", vs_low, 2 * HT);
    check("t1_first_de_ce", first_de_ce, 35 * HT + HSTART + 1);
    check("t1_last_pixel_x", last_px, HA - 1);
    check("t1_last_pixel_y", last_py, 479);
    check("t1_frame_period", last_period, 525 * HT);

    // Load mode 0 at v=200; it must wait for the frame boundary
    run_to(0, 200, 6000);
    a0 = ack_count;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
    mark_ce = ce_count;
    run_until(EV_ACK, 6000, steps);
    check("t2_ack_latency_ce", ce_count - mark_ce, 525 * HT - 1 - 200 * HT);
    check("t2_mode_after_ack", int'(cur.mode), 0);
    run_until(EV_FS, 10, steps);
    check("t2_vsync_positive", int'(cur.vsync), 1);
    run_until(EV_FS, 6000, steps);
    check("t2_frame_period", last_period, 449 * HT);
    check("t2_ack_count", ack_count - a0, 1);

    // Invalid selects pulse mode_err and leave the pending request alone
    a0 = ack_count;
    foreach (vecs[i]) begin
      applyStimulus(1'b1, 1'b0, vecs[i].ld, vecs[i].sel);
      check({vecs[i].name, "_err"}, int'(cur.err), int'(vecs[i].exp_err));
      check({vecs[i].name, "_mode"}, int'(cur.mode), int'(vecs[i].exp_mode));
    end
    run_until(EV_ACK, 6000, steps);
    check("t4_pending_kept", int'(cur.mode), 1);
    check("t4_ack_count", ack_count - a0, 1);

    // Two loads in one frame collapse into a single ack for the last one
    a0 = ack_count;
    run_to(0, 10, 200);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1);
    run_to(0, 100, 1000);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
    run_until(EV_ACK, 6000, steps);
    check("t3_mode_last_load", int'(cur.mode), 0);
    run_until(EV_FS, 10, steps);
    run_until(EV_FS, 6000, steps);
    check("t3_single_ack", ack_count - a0, 1);
    check("t3_frame_period", last_period, 449 * HT);

    // Load on the exact boundary cycle is deferred a full frame
    run_to(HT - 1, 448, 6000);
    a0 = ack_count;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd2);
    mark_ce = ce_count;
    check("t5_no_ack_on_boundary", int'(cur.ack), 0);
    check("t5_mode_unchanged", int'(cur.mode), 0);
    run_until(EV_ACK, 6000, steps);
    check("t5_ack_one_frame_later", ce_count - mark_ce, 449 * HT);
    check("t5_mode_after_ack", int'(cur.mode), 2);
    check("t5_ack_count", ack_count - a0, 1);

    // Reset mid-frame with a request pending discards it
    run_to(0, 5, 200);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd1);
    run_to(0, 300, 4000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    check("t6_reset_outputs", (cur == RESET_OBS) ? 1 : 0, 1);
    a0 = ack_count;
    run_until(EV_FS, 10, steps);
    check("t6_first_ce_frame_start", steps, 1);
    run_until(EV_FS, 6000, steps);
    check("t6_frame_period", last_period, 525 * HT);
    check("t6_no_ack", ack_count - a0, 0);
    check("t6_mode_reset", int'(cur.mode), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
